jtag_scan_master: RTL and testbench
===================================

Name: jtag_scan_master

Overview:
Host-side JTAG driver, the tester end of the TAP/TDO scan path. It takes one scan command at a time: TAP reset, IR scan or DR scan. For each command it generates TCK, TMS and TDI, samples TDO, and returns the captured bits. It sits between a test-control engine or CPU bus and the chip's JTAG pins.

Parameters:
MAX_LEN, 32, maximum scan length in bits; width of cmd_data and rsp_data.
CLK_DIV, 2, TCK half-period in clock cycles; must be >=1.

Ports:
clock  input  1  system clock.
reset  input  1  reset, asynchronous, active-high.
cmd_valid  input  1  command offered.
cmd_ready  output  1  block idle and able to accept a command.
cmd_type  input  2  00 TAP reset, 01 IR scan, 10 DR scan, 11 treated as 00.
cmd_len  input  6  scan length in bits, 1..MAX_LEN.
cmd_data  input  MAX_LEN  TDI bits, LSB shifted first.
rsp_valid  output  1  one-cycle pulse when a command completes.
rsp_data  output  MAX_LEN  captured TDO bits, right-aligned.
busy  output  1  equals ~cmd_ready.
tck  output  1  JTAG test clock.
tms  output  1  JTAG mode select.
tdi  output  1  JTAG data to target.
tdo  input  1  JTAG data from target; changes on tck falling edge.

Behaviour:
- Reset values: tck=0, tms=0, tdi=0, cmd_ready=1, rsp_valid=0, rsp_data=0, busy=0.
- Handshake: a command is accepted on a clock edge with cmd_valid&&cmd_ready. Command fields are latched at that edge. cmd_ready is 0 from the next cycle until completion.
- Length rules: cmd_len=0 is treated as 1; cmd_len>MAX_LEN is clamped to MAX_LEN. cmd_len is ignored for reset commands.
- TCK step: each TCK cycle lasts 2*CLK_DIV clocks.
  - Low phase: CLK_DIV clocks. tms and tdi are updated at the edge that starts it, i.e. the same edge that drives tck 1->0, or the first step after acceptance.
  - High phase: CLK_DIV clocks. tdo is sampled at the edge that drives tck 0->1.
- Idle: tck held 0; tms=0 and tdi=0 between commands. The TAP is assumed parked in Run-Test/Idle after every command.
- TMS sequences (N = effective length):
  - RESET: 1,1,1,1,1,0. Six steps; ends in Run-Test/Idle.
  - IR scan: header 1,1,0,0, then N shift steps with TMS=0 except 1 on the last, then 1,0. N+6 steps.
  - DR scan: header 1,0,0, then N shift steps as above, then 1,0. N+5 steps.
- TDI: cmd_data[i] is driven on shift step i. TDI=0 on all non-shift steps.
- Capture: tdo sampled on shift step i lands in rsp_data[i]. Bits >=N are 0. rsp_data=0 for RESET.
- FSM states:
  - IDLE -> HDR on accept.
  - HDR -> SHIFT after the header count; RESET goes HDR -> DONE after its 6 steps.
  - SHIFT -> TRL after N steps.
  - TRL -> DONE after 2 steps.
  - DONE -> IDLE unconditionally.
- Completion: in DONE, rsp_valid=1 for exactly one cycle, immediately after the final high phase ends, with tck=0. rsp_data is stable from that cycle until the next completion. cmd_ready=1 in that same cycle, so back-to-back accept is legal.
- Latency: accept edge to rsp_valid = steps*2*CLK_DIV + 1 clocks.
- Async reset mid-command: all outputs return to their reset values immediately. No rsp_valid. The target TAP state is undefined; the user issues RESET next.
- cmd_valid while busy is ignored (not queued).

Decomposition:
- Shared include jtag_defs.vh: cmd_type codes, FSM state encodings, header lengths (IR_HDR=4, DR_HDR=3, TRL_LEN=2, RST_LEN=6).
- One sub-module, jtag_tck_phase: CLK_DIV counter producing tck plus one-cycle fall_strobe/rise_strobe. Enabled only while busy; clears to tck=0 when disabled.
- Main block: FSM, step/bit counters, TDI shift register, TDO capture register.

Test Plan:
- RESET, CLK_DIV=2 -> tms sequence 1,1,1,1,1,0 over 6 tck cycles; rsp_valid 25 clocks after accept; rsp_data=0.
- IR scan, len=4, data=4'b0010, TAP model capturing 4'b0101 -> tms 1,1,0,0,0,0,0,1,1,0; tdi on shift steps 0,1,0,0; rsp_data=0x5; 10 tck cycles.
- DR scan, len=1, data=1, bypass model (capture 0) -> rsp_data=0; 6 tck cycles; tms 1,0,0,1,1,0.
- Two DR scans, len=32, through a 32-bit model register reset to 0: data 0xDEADBEEF then 0 -> rsp 0x0 then 0xDEADBEEF. The second command is accepted in the rsp_valid cycle of the first.
- Clamp checks: cmd_len=0 behaves as len 1; cmd_len=40 behaves as len 32; cmd_type=11 is identical to RESET.
- Assert reset during SHIFT step 5 of a 32-bit DR scan -> tck=0, tms=0, cmd_ready=1 immediately; no rsp_valid. A following RESET command completes normally.

Source files
------------

// File: rtl/jtag_scan_master_pkg.sv
//------------------------------------------------------------------------------
// Module   : jtag_scan_master_pkg
// Purpose  : Shared definitions for the JTAG scan master: command-type codes,
//            FSM state encoding, TMS header/trailer lengths and the header
//            TMS pattern lookup.
// Ports    : none (package)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package jtag_scan_master_pkg;

  // Raw cmd_type codes as presented on the command port
  localparam logic [1:0] CMD_RESET = 2'b00;
  localparam logic [1:0] CMD_IR    = 2'b01;
  localparam logic [1:0] CMD_DR    = 2'b10;

  // Step counts of the fixed TMS segments
  localparam int IR_HDR  = 4;
  localparam int DR_HDR  = 3;
  localparam int TRL_LEN = 2;
  localparam int RST_LEN = 6;

  // Latched command kind; code 11 folds into RESET at decode time
  typedef enum logic [1:0] {
    KIND_RESET = 2'd0,
    KIND_IR    = 2'd1,
    KIND_DR    = 2'd2
  } kind_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_SHIFT = 3'd2,
    ST_TRL   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic kind_t decode_kind(input logic [1:0] code);
    kind_t k;
    case (code)
      CMD_IR:  k = KIND_IR;
      CMD_DR:  k = KIND_DR;
      default: k = KIND_RESET;
    endcase
    return k;
  endfunction

  // Index of the last step of the header segment (RESET is header-only)
  function automatic logic [2:0] hdr_last(input kind_t k);
    logic [2:0] v;
    case (k)
      KIND_IR: v = 3'(IR_HDR - 1);
      KIND_DR: v = 3'(DR_HDR - 1);
      default: v = 3'(RST_LEN - 1);
    endcase
    return v;
  endfunction

  // TMS value for header step idx, starting from Run-Test/Idle:
  //   RESET 1,1,1,1,1,0   IR 1,1,0,0   DR 1,0,0
  function automatic logic hdr_tms(input kind_t k, input logic [2:0] idx);
    logic v;
    case (k)
      KIND_IR: v = (idx < 3'd2);
      KIND_DR: v = (idx == 3'd0);
      default: v = (idx != 3'(RST_LEN - 1));
    endcase
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/jtag_scan_master_tck_phase.sv
//------------------------------------------------------------------------------
// Module   : jtag_scan_master_tck_phase
// Purpose  : TCK generator. Divides the system clock into TCK cycles of
//            2*CLK_DIV clocks and flags the clock edges at which TCK falls
//            (start of a step) and rises (TDO sample point).
// Ports    : clock, reset      - system clock, async active-high reset
//            enable            - run while high; held cleared (tck=0) when low
//            tck               - JTAG test clock
//            fall_strobe       - next clock edge starts a low phase
//            rise_strobe       - next clock edge drives tck 0->1
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module jtag_scan_master_tck_phase #(
  parameter int CLK_DIV = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic tck,
  output logic fall_strobe,
  output logic rise_strobe
);

  localparam int             CW   = $clog2(2 * CLK_DIV);
  localparam logic [CW-1:0]  HALF = CW'(CLK_DIV);
  localparam logic [CW-1:0]  LAST = CW'(2 * CLK_DIV - 1);

  logic [CW-1:0] count;

  // The count is 0 right after enable rises, so the very first strobe is a
  // fall strobe: the first step starts one clock after the command is taken.
  assign fall_strobe = enable && (count == '0);
  assign rise_strobe = enable && (count == HALF);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
      tck   <= 1'b0;
    end else if (!enable) begin
      count <= '0;
      tck   <= 1'b0;
    end else begin
      count <= (count == LAST) ? '0 : count + CW'(1);
      if (rise_strobe) begin
        tck <= 1'b1;
      end else if (fall_strobe) begin
        tck <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/jtag_scan_master.sv
//------------------------------------------------------------------------------
// Module   : jtag_scan_master
// Purpose  : Host-side JTAG driver. Accepts one scan command at a time (TAP
//            reset, IR scan, DR scan), generates TCK/TMS/TDI, samples TDO
//            and returns the captured bits right-aligned.
// Ports    : clock, reset           - system clock, async active-high reset
//            cmd_valid/cmd_ready    - command handshake
//            cmd_type/len/data      - command fields (data LSB shifted first)
//            rsp_valid/rsp_data     - completion pulse and captured TDO bits
//            busy                   - ~cmd_ready
//            tck/tms/tdi/tdo        - JTAG pins
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module jtag_scan_master
  import jtag_scan_master_pkg::*;
#(
  parameter int MAX_LEN = 32,
  parameter int CLK_DIV = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_type,
  input  logic [5:0]         cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               busy,
  output logic               tck,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo
);

  // Step/bit index must reach both the header indices (0..5) and MAX_LEN-1
  localparam int IW = ($clog2(MAX_LEN) > 3) ? $clog2(MAX_LEN) : 3;

  state_t             state;
  kind_t              kind;
  logic [IW-1:0]      idx;
  logic [IW-1:0]      last_bit;
  logic               first;
  logic [MAX_LEN-1:0] tdi_sr;
  logic [MAX_LEN-1:0] capture;
  logic [IW-1:0]      len_last;
  logic               fall_strobe;
  logic               rise_strobe;

  assign busy = ~cmd_ready;

  // Effective length minus one: 0 counts as 1, oversize clamps to MAX_LEN
  always_comb begin
    len_last = '0;
    if (cmd_len == 6'd0) begin
      len_last = '0;
    end else if (int'(cmd_len) > MAX_LEN) begin
      len_last = IW'(MAX_LEN - 1);
    end else begin
      len_last = IW'(cmd_len - 6'd1);
    end
  end

  jtag_scan_master_tck_phase #(
    .CLK_DIV     (CLK_DIV)
  ) u_tck_phase (
    .clock       (clock),
    .reset       (reset),
    .enable      (busy),
    .tck         (tck),
    .fall_strobe (fall_strobe),
    .rise_strobe (rise_strobe)
  );

  // Every fall strobe ends the current step (if any) and starts the next
  // one, so tms/tdi always change together with tck 1->0. The step that
  // follows the last trailer/reset step is DONE, entered with tck already 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      kind      <= KIND_RESET;
      idx       <= '0;
      last_bit  <= '0;
      first     <= 1'b0;
      tdi_sr    <= '0;
      capture   <= '0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      tms       <= 1'b0;
      tdi       <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          state <= ST_IDLE;
          if (cmd_valid && cmd_ready) begin
            state     <= ST_HDR;
            kind      <= decode_kind(cmd_type);
            last_bit  <= len_last;
            tdi_sr    <= cmd_data;
            capture   <= '0;
            idx       <= '0;
            first     <= 1'b1;
            cmd_ready <= 1'b0;
          end
        end

        default: begin
          if (rise_strobe && (state == ST_SHIFT)) begin
            capture[idx] <= tdo;
          end
          if (fall_strobe) begin
            if (first) begin
              first <= 1'b0;
              tms   <= hdr_tms(kind, 3'd0);
              tdi   <= 1'b0;
            end else begin
              case (state)
                ST_HDR: begin
                  if (idx == IW'(hdr_last(kind))) begin
                    if (kind == KIND_RESET) begin
                      state     <= ST_DONE;
                      tms       <= 1'b0;
                      tdi       <= 1'b0;
                      rsp_valid <= 1'b1;
                      rsp_data  <= capture;
                      cmd_ready <= 1'b1;
                    end else begin
                      state  <= ST_SHIFT;
                      idx    <= '0;
                      tms    <= (last_bit == '0);
                      tdi    <= tdi_sr[0];
                      tdi_sr <= tdi_sr >> 1;
                    end
                  end else begin
                    idx <= idx + IW'(1);
                    tms <= hdr_tms(kind, idx[2:0] + 3'd1);
                    tdi <= 1'b0;
                  end
                end

                ST_SHIFT: begin
                  if (idx == last_bit) begin
                    // Exit1 already reached; trailer is Update (1) then RTI (0)
                    state <= ST_TRL;
                    idx   <= '0;
                    tms   <= 1'b1;
                    tdi   <= 1'b0;
                  end else begin
                    idx    <= idx + IW'(1);
                    tms    <= ((idx + IW'(1)) == last_bit);
                    tdi    <= tdi_sr[0];
                    tdi_sr <= tdi_sr >> 1;
                  end
                end

                ST_TRL: begin
                  if (idx == IW'(TRL_LEN - 1)) begin
                    state     <= ST_DONE;
                    tms       <= 1'b0;
                    tdi       <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_data  <= capture;
                    cmd_ready <= 1'b1;
                  end else begin
                    idx <= idx + IW'(1);
                    tms <= 1'b0;
                    tdi <= 1'b0;
                  end
                end

                default: begin
                  state <= ST_IDLE;
                end
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_jtag_scan_master.sv
//------------------------------------------------------------------------------
// Module   : tb_jtag_scan_master
// Purpose  : Self-checking bench for jtag_scan_master. A behavioural TAP
//            (4-bit IR capturing 0101, BYPASS selected by IR=0010, otherwise
//            a 32-bit register reset in Test-Logic-Reset) answers the scans.
//            Expected responses are queued at issue time and compared when
//            rsp_valid pulses, together with latency and the TMS/TDI traces.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_jtag_scan_master;

  localparam int MAX_LEN = 32;
  localparam int CLK_DIV = 2;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [1:0]         cmd_type = 2'b00;
  logic [5:0]         cmd_len = 6'd0;
  logic [MAX_LEN-1:0] cmd_data = '0;
  logic               rsp_valid;
  logic [MAX_LEN-1:0] rsp_data;
  logic               busy;
  logic               tck;
  logic               tms;
  logic               tdi;
  logic               tdo = 1'b0;

  jtag_scan_master #(
    .MAX_LEN   (MAX_LEN),
    .CLK_DIV   (CLK_DIV)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_type  (cmd_type),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .tck       (tck),
    .tms       (tms),
    .tdi       (tdi),
    .tdo       (tdo)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int rsp_pulses = 0;

  always @(posedge clock) cycle++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural TAP ----------------
  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
  } tap_e;

  tap_e        tap = TLR;
  logic [3:0]  ir = 4'b0001;
  logic [3:0]  ir_sr = 4'b0000;
  logic [31:0] dr = 32'h0;
  logic        byp = 1'b0;

  function automatic tap_e tap_next(input tap_e s, input logic m);
    case (s)
      TLR:     return m ? TLR    : RTI;
      RTI:     return m ? SEL_DR : RTI;
      SEL_DR:  return m ? SEL_IR : CAP_DR;
      CAP_DR:  return m ? EX1_DR : SH_DR;
      SH_DR:   return m ? EX1_DR : SH_DR;
      EX1_DR:  return m ? UPD_DR : PA_DR;
      PA_DR:   return m ? EX2_DR : PA_DR;
      EX2_DR:  return m ? UPD_DR : SH_DR;
      UPD_DR:  return m ? SEL_DR : RTI;
      SEL_IR:  return m ? TLR    : CAP_IR;
      CAP_IR:  return m ? EX1_IR : SH_IR;
      SH_IR:   return m ? EX1_IR : SH_IR;
      EX1_IR:  return m ? UPD_IR : PA_IR;
      PA_IR:   return m ? EX2_IR : PA_IR;
      EX2_IR:  return m ? UPD_IR : SH_IR;
      UPD_IR:  return m ? SEL_DR : RTI;
      default: return TLR;
    endcase
  endfunction

  always @(posedge tck) begin
    case (tap)
      TLR:    begin ir <= 4'b0001; dr <= 32'h0; end
      CAP_IR: ir_sr <= 4'b0101;
      SH_IR:  ir_sr <= {tdi, ir_sr[3:1]};
      UPD_IR: ir <= ir_sr;
      CAP_DR: if (ir == 4'b0010) byp <= 1'b0;
      SH_DR:  if (ir == 4'b0010) byp <= tdi; else dr <= {tdi, dr[31:1]};
      default: ;
    endcase
    tap <= tap_next(tap, tms);
  end

  always @(negedge tck) begin
    if (tap == SH_IR)      tdo <= ir_sr[0];
    else if (tap == SH_DR) tdo <= (ir == 4'b0010) ? byp : dr[0];
    else                   tdo <= 1'b0;
  end

  // ---------------- pin trace recorder ----------------
  int          rec_n = 0;
  logic [63:0] rec_tms = '0;
  logic [63:0] rec_tdi = '0;

  always @(posedge tck) begin
    if (rec_n < 64) begin
      rec_tms[rec_n] = tms;
      rec_tdi[rec_n] = tdi;
    end
    rec_n++;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int          tag;
    logic [31:0] rsp;
    int          steps;
    logic [63:0] tms_v;
    logic [63:0] tdi_v;
    int          acc;
  } exp_t;

  exp_t exp_q[$];

  // Expected pin traces straight from the command definition
  function automatic void build(input logic [1:0] t, input logic [5:0] len,
                                input logic [31:0] d, output int steps,
                                output logic [63:0] tv, output logic [63:0] dv);
    int n;
    int hdr;
    n  = (len == 6'd0) ? 1 : ((int'(len) > MAX_LEN) ? MAX_LEN : int'(len));
    tv = '0;
    dv = '0;
    if (t == 2'b01 || t == 2'b10) begin
      hdr = (t == 2'b01) ? 4 : 3;
      tv[0] = 1'b1;
      if (t == 2'b01) tv[1] = 1'b1;
      for (int i = 0; i < n; i++) dv[hdr + i] = d[i];
      tv[hdr + n - 1] = 1'b1;
      tv[hdr + n]     = 1'b1;
      steps = hdr + n + 2;
    end else begin
      tv[4:0] = 5'b11111;
      steps = 6;
    end
  endfunction

  always @(negedge clock) begin
    exp_t e;
    if (rsp_valid) begin
      rsp_pulses++;
      if (exp_q.size() == 0) begin
        check("unexpected rsp_valid", 64'(rsp_valid), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check($sformatf("cmd%0d rsp_data", e.tag), 64'(rsp_data), 64'(e.rsp));
        check($sformatf("cmd%0d latency", e.tag), 64'(cycle - e.acc),
              64'(e.steps * 2 * CLK_DIV + 1));
        check($sformatf("cmd%0d tck_cycles", e.tag), 64'(rec_n), 64'(e.steps));
        check($sformatf("cmd%0d tms_trace", e.tag), rec_tms, e.tms_v);
        check($sformatf("cmd%0d tdi_trace", e.tag), rec_tdi, e.tdi_v);
        check($sformatf("cmd%0d done_pins", e.tag), {61'd0, tck, cmd_ready, busy}, 64'b010);
      end
      rec_n   = 0;
      rec_tms = '0;
      rec_tdi = '0;
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input int tag, input logic [1:0] t, input logic [5:0] len,
                       input logic [31:0] d, input logic [31:0] rsp,
                       output logic during_rsp);
    exp_t e;
    bit   ok;
    ok = 1'b0;
    during_rsp = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check($sformatf("cmd%0d ready_wait", tag), 64'(0), 64'(1));
      return;
    end
    during_rsp = rsp_valid;
    e.tag = tag;
    e.rsp = rsp;
    e.acc = cycle + 1;
    build(t, len, d, e.steps, e.tms_v, e.tdi_v);
    exp_q.push_back(e);
    cmd_type  = t;
    cmd_len   = len;
    cmd_data  = d;
    cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
    cmd_data  = '0;
  endtask

  task automatic wait_done(input int tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clock);
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check($sformatf("cmd%0d completion_wait", tag), 64'(0), 64'(1));
      exp_q.delete();
    end
  endtask

  typedef struct {
    logic [1:0]  t;
    logic [5:0]  len;
    logic [31:0] data;
    logic [31:0] rsp;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic flag;
    int   pulses_before;
    bit   ok;

    vecs[0] = '{2'b00, 6'd0,  32'h0000_0000, 32'h0000_0000};  // TAP reset
    vecs[1] = '{2'b11, 6'd5,  32'hFFFF_FFFF, 32'h0000_0000};  // code 11 as reset
    vecs[2] = '{2'b01, 6'd4,  32'h0000_0002, 32'h0000_0005};  // IR=0010, captures 0101
    vecs[3] = '{2'b10, 6'd1,  32'h0000_0001, 32'h0000_0000};  // bypass
    vecs[4] = '{2'b01, 6'd0,  32'hFFFF_FFFF, 32'h0000_0001};  // len 0 -> 1
    vecs[5] = '{2'b10, 6'd40, 32'hDEAD_BEEF, 32'h0000_0000};  // len 40 -> 32
    vecs[6] = '{2'b10, 6'd32, 32'h0000_0000, 32'hDEAD_BEEF};

    // Reset values while reset is held and right after release
    repeat (3) @(negedge clock);
    check("reset tck",       64'(tck),       64'(0));
    check("reset tms",       64'(tms),       64'(0));
    check("reset tdi",       64'(tdi),       64'(0));
    check("reset cmd_ready", 64'(cmd_ready), 64'(1));
    check("reset rsp_valid", 64'(rsp_valid), 64'(0));
    check("reset rsp_data",  64'(rsp_data),  64'(0));
    check("reset busy",      64'(busy),      64'(0));
    reset = 1'b0;
    @(negedge clock);
    check("idle after reset", {61'd0, cmd_ready, busy, tck}, 64'b100);

    for (int v = 0; v < 7; v++) begin
      issue(v, vecs[v].t, vecs[v].len, vecs[v].data, vecs[v].rsp, flag);
      wait_done(v);
    end

    // Back-to-back DR scans through the 32-bit register
    issue(10, 2'b00, 6'd0, 32'h0, 32'h0, flag);
    wait_done(10);
    issue(11, 2'b10, 6'd32, 32'hDEAD_BEEF, 32'h0, flag);
    issue(12, 2'b10, 6'd32, 32'h0, 32'hDEAD_BEEF, flag);
    check("b2b accept in rsp_valid cycle", 64'(flag), 64'(1));
    wait_done(12);

    // Reset asserted during shift step 5 of a 32-bit DR scan
    issue(20, 2'b10, 6'd32, 32'hFFFF_FFFF, 32'h0, flag);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      if (rec_n >= 9) begin
        ok = 1'b1;
        break;
      end
    end
    check("abort reached shift step 5", 64'(ok), 64'(1));
    #2;
    reset = 1'b1;
    #1;
    check("abort tck",       64'(tck),       64'(0));
    check("abort tms",       64'(tms),       64'(0));
    check("abort tdi",       64'(tdi),       64'(0));
    check("abort cmd_ready", 64'(cmd_ready), 64'(1));
    check("abort busy",      64'(busy),      64'(0));
    check("abort rsp_data",  64'(rsp_data),  64'(0));
    exp_q.delete();
    pulses_before = rsp_pulses;
    repeat (3) @(negedge clock);
    reset   = 1'b0;
    rec_n   = 0;
    rec_tms = '0;
    rec_tdi = '0;
    repeat (40) @(negedge clock);
    check("abort no rsp_valid", 64'(rsp_pulses), 64'(pulses_before));

    issue(21, 2'b00, 6'd0, 32'h0, 32'h0, flag);
    wait_done(21);

    // 7 table commands + 3 back-to-back + 1 recovery reset
    check("rsp_valid pulse count", 64'(rsp_pulses), 64'(11));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
